// File: rtl/pe_array_sched.sv
// pe_array_sched: sequencer for a weight-stationary systolic tile built from PE_row instances.
// Loads one weight tile through the top row, then streams skewed activation vectors into
// the rows, and flags when the bottom row's out_sum carries a valid result.
// Optional build macro SCHED_STALL_CNT_EN adds a 32-bit stall_cnt output that counts
// COMPUTE cycles where the scheduler was ready but no activation vector was offered.
module pe_array_sched #(
  parameter int data_width         = 19,
  parameter int w_tile_column_size = 6,
  parameter int w_tile_row_size    = 6,
  parameter int out_latency        = 12
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [15:0]                                num_vec,
  input  logic                                       w_valid,
  output logic                                       w_ready,
  input  logic [data_width*w_tile_column_size-1:0]   w_data,
  input  logic                                       a_valid,
  output logic                                       a_ready,
  input  logic [data_width*w_tile_row_size-1:0]      a_data,
  output logic                                       w_en,
  output logic                                       w_compute,
  output logic [data_width*w_tile_column_size-1:0]   weight_out,
  output logic [data_width*w_tile_row_size-1:0]      act_out,
  output logic                                       result_valid,
  output logic                                       busy,
  output logic                                       done
`ifdef SCHED_STALL_CNT_EN
  ,
  output logic [31:0]                                stall_cnt
`endif
);

  localparam int BW = $clog2(w_tile_row_size) + 1;
  localparam int FW = $clog2(out_latency) + 1;
  localparam logic [BW-1:0] BEATS      = BW'(w_tile_row_size);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(out_latency - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] GAP     = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] FLUSH   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]             state;
  logic [15:0]            num_vec_q;
  logic [15:0]            vec_cnt;
  logic [BW-1:0]          beat_cnt;
  logic [FW-1:0]          flush_cnt;
  logic [out_latency-1:0] valid_pipe;
  logic                   w_fire;
  logic                   a_fire;

  // w_ready stays low in the trailing LOAD cycle that carries the final weight shift,
  // so the tile never takes more than w_tile_row_size beats.
  assign w_ready      = (state == LOAD) && (beat_cnt < BEATS);
  assign a_ready      = (state == COMPUTE) && (vec_cnt < num_vec_q);
  assign w_fire       = w_valid & w_ready;
  assign a_fire       = a_valid & a_ready;
  assign w_compute    = (state == COMPUTE) || (state == FLUSH);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign result_valid = valid_pipe[out_latency-1];

  // Tile sequencing: load weights, one quiet cycle, compute, flush the array, report done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      num_vec_q <= '0;
      vec_cnt   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            num_vec_q <= num_vec;
            vec_cnt   <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
          end
        end
        LOAD: begin
          if (w_fire) begin
            beat_cnt <= beat_cnt + BW'(1);
          end
          if (beat_cnt == BEATS) begin
            state <= GAP;
          end
        end
        GAP: begin
          flush_cnt <= '0;
          state     <= (num_vec_q == 16'd0) ? FLUSH : COMPUTE;
        end
        COMPUTE: begin
          if (a_fire) begin
            vec_cnt <= vec_cnt + 16'd1;
            if (vec_cnt == num_vec_q - 16'd1) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state <= DONE;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Weight beats are registered toward the top row and shifted in on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en       <= 1'b0;
      weight_out <= '0;
    end else begin
      w_en <= w_fire;
      if (w_fire) begin
        weight_out <= w_data;
      end
    end
  end

  // Accept strobes travel through a fixed-length pipe that mirrors the array latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe <= '0;
    end else begin
      valid_pipe <= {valid_pipe[out_latency-2:0], a_fire};
    end
  end

  // Row r gets an r+1 deep delay line; bubbles inject zeros into the array.
  for (genvar r = 0; r < w_tile_row_size; r++) begin : g_skew
    logic [data_width-1:0] stage [0:r];

    // Shift this row's activation slice down its skew chain.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= r; j++) begin
          stage[j] <= '0;
        end
      end else begin
        stage[0] <= a_fire ? a_data[r*data_width +: data_width] : '0;
        for (int j = 1; j <= r; j++) begin
          stage[j] <= stage[j-1];
        end
      end
    end

    assign act_out[r*data_width +: data_width] = stage[r];
  end

`ifdef SCHED_STALL_CNT_EN
  // Count starved compute cycles per tile, saturating rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if ((state == COMPUTE) && a_ready && !a_valid && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_array_sched.sv
// tb_pe_array_sched: randomized self-checking bench for pe_array_sched.
// The reference model works from event timestamps (when beats and vectors were accepted,
// when the tile ends) rather than from a state machine. Define SCHED_STALL_CNT_EN to
// also check the stall counter.
module tb_pe_array_sched;

  localparam int DW   = 19;
  localparam int COLS = 6;
  localparam int ROWS = 6;
  localparam int LAT  = 12;
  localparam int WW   = DW * COLS;
  localparam int AW   = DW * ROWS;
  localparam int HMAX = 4096;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [15:0]   num_vec;
  logic          w_valid;
  logic          w_ready;
  logic [WW-1:0] w_data;
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_data;
  logic          w_en;
  logic          w_compute;
  logic [WW-1:0] weight_out;
  logic [AW-1:0] act_out;
  logic          result_valid;
  logic          busy;
  logic          done;
`ifdef SCHED_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  pe_array_sched #(
    .data_width(DW), .w_tile_column_size(COLS), .w_tile_row_size(ROWS), .out_latency(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .w_en(w_en), .w_compute(w_compute), .weight_out(weight_out), .act_out(act_out),
    .result_valid(result_valid), .busy(busy), .done(done)
`ifdef SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int floor_cyc = 0;

  // Reference model: acceptance history plus tile milestones.
  bit            hist_w  [0:HMAX-1];
  bit            hist_a  [0:HMAX-1];
  logic [AW-1:0] hist_ad [0:HMAX-1];
  bit            m_busy = 1'b0;
  int            nv_m   = 0;
  int            wcnt   = 0;
  int            acnt   = 0;
  int            lw     = -1;
  int            dcyc   = -1;
  logic [WW-1:0] m_wout = '0;
  logic [31:0]   m_stall = '0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic bit hw(input int i);
    return (i >= floor_cyc && i >= 0) ? hist_w[i] : 1'b0;
  endfunction

  function automatic bit ha(input int i);
    return (i >= floor_cyc && i >= 0) ? hist_a[i] : 1'b0;
  endfunction

  // One clock cycle: compare every output with the model at the falling edge, then
  // record handshakes and advance the model.
  task automatic stepCycle();
    bit wr, ar, wc, wacc, aacc;
    int g, idx;
    logic [AW-1:0] ea;
    @(negedge clk);
    g  = (lw >= 0) ? lw + 2 : -1;
    wr = m_busy && (wcnt < ROWS);
    ar = m_busy && (lw >= 0) && (cyc > g) && (acnt < nv_m);
    wc = m_busy && (lw >= 0) && (cyc > g) && ((dcyc < 0) || (cyc < dcyc));
    ea = '0;
    for (int r = 0; r < ROWS; r++) begin
      idx = cyc - r - 1;
      if (ha(idx)) ea[r*DW +: DW] = hist_ad[idx][r*DW +: DW];
    end
    checkOutput("w_ready", w_ready, wr);
    checkOutput("a_ready", a_ready, ar);
    checkOutput("w_en", w_en, hw(cyc - 1));
    checkOutput("weight_out", weight_out, m_wout);
    checkOutput("w_compute", w_compute, wc);
    checkOutput("act_out", act_out, ea);
    checkOutput("result_valid", result_valid, ha(cyc - LAT));
    checkOutput("busy", busy, m_busy);
    checkOutput("done", done, m_busy && (cyc == dcyc));
`ifdef SCHED_STALL_CNT_EN
    checkOutput("stall_cnt", stall_cnt, m_stall);
`endif
    wacc = w_valid && wr;
    aacc = a_valid && ar;
    hist_w[cyc]  = wacc;
    hist_a[cyc]  = aacc;
    hist_ad[cyc] = a_data;
    if (ar && !a_valid && (m_stall != '1)) m_stall++;
    if (wacc) begin
      m_wout = w_data;
      wcnt++;
      if (wcnt == ROWS) begin
        lw = cyc;
        if (nv_m == 0) dcyc = cyc + 2 + LAT + 1;
      end
    end
    if (aacc) begin
      acnt++;
      if (acnt == nv_m) dcyc = cyc + LAT + 1;
    end
    if (m_busy && (cyc == dcyc)) begin
      m_busy = 1'b0;
    end else if (!m_busy && start) begin
      m_busy  = 1'b1;
      nv_m    = int'(num_vec);
      wcnt    = 0;
      acnt    = 0;
      lw      = -1;
      dcyc    = -1;
      m_stall = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= HMAX) begin
      $display("[TB] FAIL history_overflow cycle %0d: got %0d expected below %0d", cyc, cyc, HMAX);
      $fatal(1, "[TB] history exhausted");
    end
  endtask

  // Drive all inputs for the current cycle.
  // wmode 0: w_valid always high, 1: alternating, 2: random. Weights 1..N unless random.
  // amode 100: a_valid always high, -1: low until 3 starved cycles, else percent chance.
  task automatic applyStimulus(input int wmode, input int amode, input int k);
    logic [127:0] big;
    case (wmode)
      0:       w_valid = 1'b1;
      1:       w_valid = (k % 2 == 1);
      default: w_valid = 1'($urandom_range(0, 1));
    endcase
    if (wmode < 2) begin
      w_data = WW'(wcnt + 1);
    end else begin
      big    = {$urandom, $urandom, $urandom, $urandom};
      w_data = big[WW-1:0];
    end
    if (amode == 100)     a_valid = 1'b1;
    else if (amode == -1) a_valid = (m_stall >= 3);
    else                  a_valid = ($urandom_range(0, 99) < amode);
    if (amode == 100 || amode == -1) begin
      for (int r = 0; r < ROWS; r++) a_data[r*DW +: DW] = DW'(r + 16 * acnt);
    end else begin
      big    = {$urandom, $urandom, $urandom, $urandom};
      a_data = big[AW-1:0];
    end
    if (m_busy && ($urandom_range(0, 9) == 0)) begin
      start   = 1'b1;
      num_vec = 16'($urandom_range(0, 40));
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic clearInputs();
    start = 1'b0; num_vec = '0; w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
  endtask

  // Assert reset between edges and expect every output to clear without a clock.
  task automatic applyReset();
    clearInputs();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_w_ready", w_ready, 1'b0);
    checkOutput("rst_a_ready", a_ready, 1'b0);
    checkOutput("rst_w_en", w_en, 1'b0);
    checkOutput("rst_w_compute", w_compute, 1'b0);
    checkOutput("rst_weight_out", weight_out, '0);
    checkOutput("rst_act_out", act_out, '0);
    checkOutput("rst_result_valid", result_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
`ifdef SCHED_STALL_CNT_EN
    checkOutput("rst_stall_cnt", stall_cnt, '0);
`endif
    @(posedge clk);
    #1;
    cyc++;
    rst_n     = 1'b1;
    floor_cyc = cyc;
    m_busy    = 1'b0;
    m_wout    = '0;
    m_stall   = '0;
    lw        = -1;
    dcyc      = -1;
  endtask

  task automatic runTile(input int nv, input int wmode, input int amode, input int rst_at);
    int k;
    applyStimulus(wmode, amode, 0);
    start   = 1'b1;
    num_vec = 16'(nv);
    stepCycle();
    k = 1;
    while (m_busy && k < 2000) begin
      if (k == rst_at) begin
        applyReset();
        break;
      end
      applyStimulus(wmode, amode, k);
      stepCycle();
      k++;
    end
    if (k >= 2000) begin
      checks++;
      errors++;
      $display("[TB] FAIL tile_budget cycle %0d: got busy after %0d cycles expected idle", cyc, k);
    end
    clearInputs();
    repeat (2) stepCycle();
  endtask

  initial begin
    clearInputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    applyReset();
    repeat (5) stepCycle();
    $display("[TB] weights 1..6 back to back, four patterned vectors");
    runTile(4, 0, 100, 0);
    $display("[TB] alternating weight valid");
    runTile(4, 1, 100, 0);
    $display("[TB] empty tile");
    runTile(0, 0, 100, 0);
    $display("[TB] reset in the middle of compute");
    runTile(10, 0, 100, 12);
    runTile(3, 2, 70, 0);
    $display("[TB] three starved compute cycles");
    runTile(5, 0, -1, 0);
    for (int t = 0; t < 6; t++) begin
      runTile($urandom_range(0, 20), 2, 60, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
